// File: rtl/ma_sched_pkg.sv
// Shared types and width helpers for the multi-channel moving-average scheduler.
package ma_sched_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_LOG2N      = 3;
  localparam int DEF_DATA_WIDTH = 16;

  // A 2^n-sample window of DATA_WIDTH samples needs n extra bits of headroom.
  function automatic int acc_width(input int data_width, input int log2n);
    return data_width + log2n;
  endfunction

  localparam int ACC_WIDTH = acc_width(DEF_DATA_WIDTH, DEF_LOG2N);

  typedef logic [$clog2(DEF_NUM_CH)-1:0]  ch_id_t;
  typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;
  typedef logic signed [ACC_WIDTH-1:0]      acc_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      enable,
  input  logic                      advance,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] grant_idx
);

  localparam int CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] PTR_ONE = 1;

  logic [CW-1:0] ptr;
  logic [CW-1:0] idx;
  logic          found;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr + CW'(i);
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset)        ptr <= '0;
    else if (advance) ptr <= grant_idx + PTR_ONE;
  end

endmodule

// File: rtl/ma_channel_scheduler.sv
// Shares one sliding-window sum engine across NUM_CH sample streams, emitting
// one channel-tagged average per accepted sample.
module ma_channel_scheduler
  import ma_sched_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int n          = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic                         clear_valid,
  input  logic [$clog2(NUM_CH)-1:0]    clear_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NUM_CH)-1:0]    out_ch,
  output logic [DATA_WIDTH-1:0]        out_avg,
  output logic                         out_warm
);

  localparam int CW    = $clog2(NUM_CH);
  localparam int N     = 1 << n;
  localparam int ACC_W = acc_width(DATA_WIDTH, n);

  localparam logic [n-1:0] WP_ONE    = 1;
  localparam logic [n:0]   FILL_ONE  = 1;
  localparam logic [n:0]   FILL_FULL = N;
  localparam logic [n+1:0] WARM_AT   = N;

  logic [NUM_CH-1:0] clear_mask;
  logic [NUM_CH-1:0] req;
  logic              stall;
  logic              xfer;
  logic [CW-1:0]     sel_ch;

  logic signed [DATA_WIDTH-1:0] ch_sample [NUM_CH];
  logic signed [DATA_WIDTH-1:0] ch_oldest [NUM_CH];
  logic signed [ACC_W-1:0]      ch_sum    [NUM_CH];
  logic [n:0]                   ch_fill   [NUM_CH];

  logic signed [ACC_W-1:0]      new_sum;
  logic signed [DATA_WIDTH-1:0] avg_next;
  logic [n+1:0]                 fill_inc;

  // A channel being flushed drops out of arbitration for that cycle.
  assign clear_mask = clear_valid ? (NUM_CH'(1) << clear_ch) : '0;
  assign req        = in_valid & ~clear_mask;
  assign stall      = out_valid & ~out_ready;
  assign xfer       = |in_ready;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .enable    (!stall),
    .advance   (xfer),
    .grant     (in_ready),
    .grant_idx (sel_ch)
  );

  assign new_sum  = ch_sum[sel_ch] - ACC_W'(ch_oldest[sel_ch]) + ACC_W'(ch_sample[sel_ch]);
  assign avg_next = DATA_WIDTH'(new_sum >>> n);
  assign fill_inc = {1'b0, ch_fill[sel_ch]} + {{(n+1){1'b0}}, 1'b1};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] ring [N];
    logic [n-1:0]                 wp;
    logic [n:0]                   fill;
    logic signed [ACC_W-1:0]      sum;

    assign ch_sample[c] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign ch_oldest[c] = ring[wp];
    assign ch_sum[c]    = sum;
    assign ch_fill[c]   = fill;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        // NOTE: the ring is flop-based and must reset, since unfilled slots stand in for zero samples in the sum.
        for (int i = 0; i < N; i++) ring[i] <= '0;
        wp   <= '0;
        fill <= '0;
        sum  <= '0;
      end else if (clear_mask[c]) begin
        for (int i = 0; i < N; i++) ring[i] <= '0;
        wp   <= '0;
        fill <= '0;
        sum  <= '0;
      end else if (in_ready[c]) begin
        ring[wp] <= ch_sample[c];
        wp       <= wp + WP_ONE;
        sum      <= new_sum;
        if (fill != FILL_FULL) fill <= fill + FILL_ONE;
      end
    end
  end

  // Output stage holds under back-pressure; a clear never touches it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_avg   <= '0;
      out_warm  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_ch    <= sel_ch;
      out_avg   <= avg_next;
      out_warm  <= (fill_inc >= WARM_AT);
    end else if (!stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ma_channel_scheduler.sv
// Directed bench for ma_channel_scheduler (NUM_CH=4, n=2, DATA_WIDTH=16).
module tb_ma_channel_scheduler;
  import ma_sched_pkg::*;

  localparam int NUM_CH = 4;
  localparam int LOG2N  = 2;
  localparam int DW     = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_CH-1:0]      in_valid;
  logic [NUM_CH*DW-1:0]   in_data;
  logic [NUM_CH-1:0]      in_ready;
  logic                   clear_valid;
  ch_id_t                 clear_ch;
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_ch;
  logic signed [DW-1:0]   out_avg;
  logic                   out_warm;

  int n_checks = 0;
  int n_fails  = 0;

  ma_channel_scheduler #(.NUM_CH(NUM_CH), .n(LOG2N), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .clear_valid (clear_valid),
    .clear_ch    (clear_ch),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_avg     (out_avg),
    .out_warm    (out_warm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int ch, input int data);
    sample_t s;
    s = sample_t'(data);
    in_data[ch*DW +: DW] = s;
  endtask

  // Offer one sample on a lone channel and check the registered result.
  task automatic send(input string tag, input int ch, input int data, input int exp_avg, input int exp_warm);
    set_sample(ch, data);
    in_valid = NUM_CH'(1) << ch;
    #1;
    check({tag, ".grant"}, int'(in_ready), 1 << ch);
    step();
    in_valid = '0;
    check({tag, ".valid"}, int'(out_valid), 1);
    check({tag, ".ch"},    int'(out_ch), ch);
    check({tag, ".avg"},   int'(out_avg), exp_avg);
    check({tag, ".warm"},  int'(out_warm), exp_warm);
  endtask

  task automatic clear(input int ch);
    clear_valid = 1'b1;
    clear_ch    = ch_id_t'(ch);
    step();
    clear_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".valid"}, int'(out_valid), 0);
    check({tag, ".ch"},    int'(out_ch), 0);
    check({tag, ".avg"},   int'(out_avg), 0);
    check({tag, ".warm"},  int'(out_warm), 0);
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = '0;
    in_data     = '0;
    clear_valid = 1'b0;
    clear_ch    = '0;
    out_ready   = 1'b1;
    #12;
    check_idle_outputs("reset");
    check("reset.ready", int'(in_ready), 0);
    step();
    reset = 1'b0;

    // Single-channel ramp: sums 4,12,24,40,56.
    send("ramp0", 0, 4,  1,  0);
    send("ramp1", 0, 8,  3,  0);
    send("ramp2", 0, 12, 6,  0);
    send("ramp3", 0, 16, 10, 1);
    send("ramp4", 0, 20, 14, 1);
    step();
    check("ramp.drop", int'(out_valid), 0);

    // All channels requesting from reset: grants 0,1,2,3,0,1 with no gaps.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step();
    for (int c = 0; c < NUM_CH; c++) set_sample(c, 4);
    in_valid = '1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("rr.grant", int'(in_ready), 1 << (i % 4));
      if (i > 0) begin
        check("rr.valid", int'(out_valid), 1);
        check("rr.ch",    int'(out_ch), (i - 1) % 4);
        check("rr.avg",   int'(out_avg), (i - 1 < 4) ? 1 : 2);
      end
      step();
    end
    check("rr.last_ch",  int'(out_ch), 1);
    check("rr.last_avg", int'(out_avg), 2);

    // Back-pressure: outputs hold, no grants, then resume at ch2.
    out_ready = 1'b0;
    #1;
    check("stall.ready", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.valid", int'(out_valid), 1);
      check("stall.ch",    int'(out_ch), 1);
      check("stall.avg",   int'(out_avg), 2);
      check("stall.ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("resume.grant2", int'(in_ready), 4);
    step();
    check("resume.ch2",    int'(out_ch), 2);
    check("resume.avg2",   int'(out_avg), 2);
    check("resume.grant3", int'(in_ready), 8);
    step();
    check("resume.ch3",    int'(out_ch), 3);
    check("resume.avg3",   int'(out_avg), 2);
    in_valid = '0;
    step();
    check("resume.drop", int'(out_valid), 0);

    // Negative samples on ch1 (history 4,4 already present).
    send("neg0", 1, -8, 0,  0);
    send("neg1", 1, -8, -2, 1);
    send("neg2", 1, -8, -5, 1);
    send("neg3", 1, -8, -8, 1);
    clear(2);
    send("floor", 2, -1, -1, 0);
    clear(3);
    send("full0", 3, 32767, 8191,  0);
    send("full1", 3, 32767, 16383, 0);
    send("full2", 3, 32767, 24575, 0);
    send("full3", 3, 32767, 32767, 1);

    // Clear racing a request: ch0 skipped, ch1 granted, ch0 restarts cold.
    clear(0);
    send("warm0", 0, 10, 2,  0);
    send("warm1", 0, 10, 5,  0);
    send("warm2", 0, 10, 7,  0);
    send("warm3", 0, 10, 10, 1);
    send("ptr_to0", 3, 0, 24575, 1);
    set_sample(0, 4);
    set_sample(1, 0);
    in_valid    = 4'b0011;
    clear_valid = 1'b1;
    clear_ch    = 2'd0;
    #1;
    check("clr.grant", int'(in_ready), 2);
    step();
    in_valid    = '0;
    clear_valid = 1'b0;
    check("clr.ch",   int'(out_ch), 1);
    check("clr.avg",  int'(out_avg), -6);
    check("clr.warm", int'(out_warm), 1);
    send("after_clr", 0, 4, 1, 0);

    // Asynchronous reset while a result is pending.
    send("pre_rst", 3, 0, 16383, 1);
    reset = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    step();
    reset = 1'b0;
    set_sample(0, 8);
    set_sample(2, 8);
    in_valid = 4'b0101;
    #1;
    check("post_rst.grant0", int'(in_ready), 1);
    step();
    check("post_rst.ch0",    int'(out_ch), 0);
    check("post_rst.avg0",   int'(out_avg), 2);
    check("post_rst.grant2", int'(in_ready), 4);
    step();
    in_valid = '0;
    check("post_rst.ch2",   int'(out_ch), 2);
    check("post_rst.avg2",  int'(out_avg), 2);
    check("post_rst.warm2", int'(out_warm), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fails);
    $finish;
  end

endmodule
